// File: rtl/ssp_tx_fifo_if.sv
// ----------------------------------------------------------------------------
// ssp_tx_fifo_if
// Bundles the host write port and the transmitter-side port of the SSP
// transmit FIFO.
//
// Host side      : psel, pwrite, pwdata (to FIFO); ssptxintr (FIFO full)
// Transmit side  : tx_data, tx_empty, tx_count (from FIFO); tx_done (to FIFO)
// Optional       : tx_ovf sticky dropped-write flag, present only when
//                  SSP_TX_OVERFLOW_EN is defined.
//
// Modports
//   slave  : the FIFO itself
//   master : the environment (host + transmitter) driving the FIFO
// ----------------------------------------------------------------------------
interface ssp_tx_fifo_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             psel;
    logic             pwrite;
    logic [WIDTH-1:0] pwdata;
    logic             ssptxintr;
    logic [WIDTH-1:0] tx_data;
    logic             tx_empty;
    logic             tx_done;
    logic [AW:0]      tx_count;
`ifdef SSP_TX_OVERFLOW_EN
    logic             tx_ovf;

    modport slave (
        input  psel, pwrite, pwdata, tx_done,
        output ssptxintr, tx_data, tx_empty, tx_count, tx_ovf
    );

    modport master (
        output psel, pwrite, pwdata, tx_done,
        input  ssptxintr, tx_data, tx_empty, tx_count, tx_ovf
    );
`else
    modport slave (
        input  psel, pwrite, pwdata, tx_done,
        output ssptxintr, tx_data, tx_empty, tx_count
    );

    modport master (
        output psel, pwrite, pwdata, tx_done,
        input  ssptxintr, tx_data, tx_empty, tx_count
    );
`endif
endinterface : ssp_tx_fifo_if

// File: rtl/ssp_tx_fifo.sv
// ----------------------------------------------------------------------------
// ssp_tx_fifo
// Transmit FIFO feeding the SSP transmitter. The host pushes bytes with
// psel&pwrite; the head entry is presented show-ahead on tx_data. One entry
// is popped per rising edge of tx_done (a long tx_done pulse pops once).
// ssptxintr is raised while the FIFO is full.
//
// Ports
//   pclk      : clock, all state on the rising edge
//   pclear_b  : asynchronous active-low reset
//   bus       : ssp_tx_fifo_if.slave
//               psel/pwrite/pwdata  host write request and data
//               ssptxintr           FIFO full
//               tx_data             head-of-FIFO data (show-ahead)
//               tx_empty            FIFO empty
//               tx_done             transmitter frame complete (level)
//               tx_count            occupancy 0..DEPTH
//               tx_ovf              sticky dropped-write flag (optional)
//
// Optional feature macro: SSP_TX_OVERFLOW_EN
//   When defined, tx_ovf is set by any write dropped because the FIFO was full
//   with no simultaneous pop, and cleared by a host read cycle (psel & ~pwrite).
//   A set in the same cycle as a clear wins.
// ----------------------------------------------------------------------------
module ssp_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          pclk,
    input  logic          pclear_b,
    ssp_tx_fifo_if.slave  bus
);

    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE_C = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_ZERO_C = (AW+1)'(1'b0);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1'b1);

    // Storage, deliberately not reset
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          done_q, done_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;

    logic wr_req_s;
    logic pop_req_s;
    logic pop_s;
    logic full_s;
    logic wr_ok_s;

`ifdef SSP_TX_OVERFLOW_EN
    logic ovf_q, ovf_d;
    logic drop_s;
    logic rd_cyc_s;
`endif

    // Request decode: write acceptance and edge-detected pop
    always_comb begin
        wr_req_s  = bus.psel & bus.pwrite;
        full_s    = (count_q == DEPTH_C);
        // Only the rising edge of tx_done counts, so a held tx_done pops once.
        pop_req_s = bus.tx_done & ~done_q;
        pop_s     = pop_req_s & (count_q != CNT_ZERO_C);
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        wr_ok_s   = wr_req_s & (~full_s | pop_s);
    end

    // Next-state for pointers, occupancy, edge detector and flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        done_d   = bus.tx_done;

        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase

        // Flags are registered from the next occupancy so they line up with count_q.
        empty_d = (count_d == CNT_ZERO_C);
        full_d  = (count_d == DEPTH_C);
    end

    // State register for pointers, occupancy, edge detector and flags
    always_ff @(posedge pclk or negedge pclear_b) begin
        if (!pclear_b) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            done_q   <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage write port
    always_ff @(posedge pclk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= bus.pwdata;
        end
    end

`ifdef SSP_TX_OVERFLOW_EN
    // Sticky overflow next-state: set on a dropped write, cleared by a host read
    always_comb begin
        drop_s   = wr_req_s & full_s & ~pop_s;
        rd_cyc_s = bus.psel & ~bus.pwrite;
        ovf_d    = ovf_q;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (rd_cyc_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Sticky overflow register
    always_ff @(posedge pclk or negedge pclear_b) begin
        if (!pclear_b) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.tx_ovf = ovf_q;
`endif

    // Show-ahead head data from the registered read pointer
    assign bus.tx_data   = mem_q[rd_ptr_q];
    assign bus.tx_empty  = empty_q;
    assign bus.ssptxintr = full_q;
    assign bus.tx_count  = count_q;

endmodule : ssp_tx_fifo
